// File: rtl/rv_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rv_rr_arbiter
//   N-input round-robin arbiter for ready/valid streams. Merges NumPorts
//   requesters onto one registered output beat (1-cycle latency, one beat
//   per cycle) and reports the index of the requester that owns the beat.
//
// Parameters
//   NumPorts   number of requesters (2..16)
//   DataWidth  payload width per beat
//   IdxWidth   grant index width, derived from NumPorts
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_valid   per-requester valid
//   in_data    per-requester payload, port i at [i*DataWidth +: DataWidth]
//   in_last    per-requester end-of-packet flag
//   in_ready   per-requester ready, at most one bit set
//   out_valid  registered output valid
//   out_data   registered output payload
//   out_last   registered copy of the accepted in_last
//   out_idx    index of the requester whose beat is in out_data
//   out_ready  downstream ready
//
// Build option
//   RV_ARB_LOCK_EN  when defined, a beat with in_last=0 locks the grant to
//                   its port until that port delivers a beat with in_last=1.
// ---------------------------------------------------------------------------
module rv_rr_arbiter #(
   parameter  int NumPorts  = 4,
   parameter  int DataWidth = 8,
   localparam int IdxWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NumPorts-1:0]           in_valid,
   input  logic [NumPorts*DataWidth-1:0] in_data,
   input  logic [NumPorts-1:0]           in_last,
   output logic [NumPorts-1:0]           in_ready,
   output logic                          out_valid,
   output logic [DataWidth-1:0]          out_data,
   output logic                          out_last,
   output logic [IdxWidth-1:0]           out_idx,
   input  logic                          out_ready
);

   logic                 r_out_valid;
   logic [DataWidth-1:0] r_out_data;
   logic                 r_out_last;
   logic [IdxWidth-1:0]  r_out_idx;
   logic [IdxWidth-1:0]  r_ptr;

`ifdef RV_ARB_LOCK_EN
   logic                 r_lock;
   logic [IdxWidth-1:0]  r_lock_idx;
`endif

   logic                 w_can_load;
   logic                 w_any;
   logic                 w_accept;
   logic [IdxWidth-1:0]  w_sel;
   logic [IdxWidth-1:0]  w_scan_idx;
   logic [IdxWidth-1:0]  w_ptr_nxt;
   logic [DataWidth-1:0] w_data;
   logic                 w_last;

   assign w_can_load = !r_out_valid || out_ready;

   // Priority scan starting at r_ptr; the first valid requester wins.
   always_comb begin
      w_sel      = '0;
      w_any      = 1'b0;
      w_scan_idx = '0;
      for (int unsigned k = 0; k < NumPorts; k++) begin
         w_scan_idx = IdxWidth'((32'(r_ptr) + k) % NumPorts);
         if (!w_any && in_valid[w_scan_idx]) begin
            w_any = 1'b1;
            w_sel = w_scan_idx;
         end
      end
`ifdef RV_ARB_LOCK_EN
      // A locked packet owns the output even while its source idles.
      if (r_lock) begin
         w_sel = r_lock_idx;
         w_any = in_valid[r_lock_idx];
      end
`endif
   end

   assign w_accept  = w_can_load && w_any && !rst;
   assign w_ptr_nxt = (w_sel == IdxWidth'(NumPorts - 1)) ? '0 : w_sel + 1'b1;
   assign w_last    = in_last[w_sel];

   always_comb begin
      in_ready = '0;
      w_data   = '0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         if (w_sel == IdxWidth'(i)) begin
            in_ready[i] = w_accept;
            w_data      = in_data[i*DataWidth +: DataWidth];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_idx   <= '0;
         r_ptr       <= '0;
`ifdef RV_ARB_LOCK_EN
         r_lock      <= 1'b0;
         r_lock_idx  <= '0;
`endif
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_last  <= w_last;
            r_out_idx   <= w_sel;
`ifdef RV_ARB_LOCK_EN
            // Pointer only moves once the packet completes.
            if (w_last) begin
               r_lock <= 1'b0;
               r_ptr  <= w_ptr_nxt;
            end else begin
               r_lock     <= 1'b1;
               r_lock_idx <= w_sel;
            end
`else
            r_ptr <= w_ptr_nxt;
`endif
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_idx   = r_out_idx;

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv_rr_arbiter
//   Self-checking bench for rv_rr_arbiter (NumPorts=4, DataWidth=8, default
//   build). Directed phases push hand-computed beats into a queue; a monitor
//   on the falling edge pops and compares every consumed output beat. A
//   randomised phase tracks accepted beats per port and checks ordering.
// ---------------------------------------------------------------------------
module tb_rv_rr_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   typedef struct packed {
      logic [1:0]   idx;
      logic         last;
      logic [W-1:0] data;
   } beat_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_last  = '0;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   d [N];
   logic [N*W-1:0] in_data;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_last;
   logic [1:0]     out_idx;
   logic           out_ready = 1'b1;

   beat_t      exp_q[$];
   logic [8:0] port_q[N][$];
   int         total = 0;
   int         bad   = 0;
   bit         rand_mode = 1'b0;

   assign in_data = {d[3], d[2], d[1], d[0]};

   always #5 clk = ~clk;

   rv_rr_arbiter #(.NumPorts(N), .DataWidth(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_idx   (out_idx),
      .out_ready (out_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int idx);
      beat_t b;
      b.idx  = 2'(idx);
      b.last = in_last[idx];
      b.data = d[idx];
      exp_q.push_back(b);
   endtask

   task automatic summary();
      $display("test done: total=%0d bad=%0d", total, bad);
   endtask

   // Monitor: checks reset state, one-hot ready and every consumed beat.
   always @(negedge clk) begin
      beat_t      e;
      logic [8:0] pe;
      if (rst) begin
         check("rst_out_valid", 32'(out_valid), 0);
         check("rst_in_ready",  32'(in_ready),  0);
         check("rst_out_idx",   32'(out_idx),   0);
      end else begin
         check("ready_onehot", 32'($countones(in_ready) <= 1), 1);
         if (out_valid && out_ready) begin
            if (rand_mode) begin
               if (port_q[out_idx].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rand_unexpected: got beat idx=%0d data=%0h expected none", out_idx, out_data);
               end else begin
                  pe = port_q[out_idx].pop_front();
                  check("rand_beat", 32'({out_last, out_data}), 32'(pe));
               end
            end else if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL dir_unexpected: got beat idx=%0d data=%0h expected none", out_idx, out_data);
            end else begin
               e = exp_q.pop_front();
               check("dir_beat", 32'({out_idx, out_last, out_data}), 32'(e));
            end
         end
      end
   end

   initial begin
      #200000;
      total++;
      bad++;
      $display("FAIL watchdog: got timeout expected finish");
      summary();
      $finish;
   end

   initial begin
      int cnt[N];
      int accepted;
      accepted = 0;
      for (int i = 0; i < N; i++) begin
         d[i]   = 8'hA0 + 8'(i);
         cnt[i] = 0;
      end

      // Reset held two cycles with every requester valid.
      rst       = 1'b1;
      in_valid  = 4'hF;
      in_last   = 4'b1010;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Fair rotation starting at port 0.
      for (int k = 0; k < 8; k++) push(k % 4);
      for (int k = 0; k < 8; k++) tick();
      in_valid = '0;
      tick();
      tick();

      // Backpressure: load A0, stall three cycles, then release.
      push(0);
      push(1);
      push(2);
      in_valid  = 4'hF;
      out_ready = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         check("bp_valid", 32'(out_valid), 1);
         check("bp_data",  32'(out_data),  32'h A0);
         check("bp_idx",   32'(out_idx),   0);
         check("bp_ready", 32'(in_ready),  0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      tick();
      in_valid = '0;
      tick();
      tick();

      // Sparse requests with pointer wrap (ptr starts at 3).
      push(3);
      in_valid = 4'b1000;
      tick();
      push(1);
      in_valid = 4'b0010;
      tick();
      push(0);
      push(1);
      in_valid = 4'b0011;
      tick();
      tick();
      in_valid = '0;
      tick();
      tick();
      check("dir_queue_empty", 32'(exp_q.size()), 0);

      // Randomised traffic with per-port ordering checks.
      rand_mode = 1'b1;
      for (int c = 0; c < 300; c++) begin
         in_valid  = 4'($urandom);
         in_last   = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) d[i] = {2'(i), 6'(cnt[i])};
         #2;
         for (int i = 0; i < N; i++) begin
            if (in_valid[i] && in_ready[i]) begin
               port_q[i].push_back({in_last[i], d[i]});
               cnt[i]++;
               accepted++;
            end
         end
         tick();
      end
      in_valid  = '0;
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      for (int i = 0; i < N; i++) check("rand_drain", 32'(port_q[i].size()), 0);
      check("rand_accepts", 32'(accepted > 100), 1);

      summary();
      $finish;
   end

endmodule
